// File: rtl/urp_pcie_pkg.sv
// rtl/urp_pcie_pkg.sv - shared constants and FSM state type for the PCIe flit CRC checker
package urp_pcie_pkg;

    localparam logic [31:0] GEN_POLY        = 32'h814141AB;
    localparam int          DATA_WIDTH_DEF  = 224;
    localparam int          CRC_WIDTH_DEF   = 32;
    localparam int          FIFO_DEPTH      = 2;

    typedef enum logic {
        ST_CHECK = 1'b0,
        ST_DROP  = 1'b1
    } flit_state_e;

endpackage

// File: rtl/urp_pcie_crc32_gen.sv
// rtl/urp_pcie_crc32_gen.sv - combinational MSB-first CRC, init 0, no reflection, no final XOR
module urp_pcie_crc32_gen
    import urp_pcie_pkg::*;
#(
    parameter int                   DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int                   CRC_WIDTH  = CRC_WIDTH_DEF,
    parameter logic [CRC_WIDTH-1:0] POLY       = CRC_WIDTH'(GEN_POLY)
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [CRC_WIDTH-1:0]  crc_o
);

    logic [CRC_WIDTH-1:0] crc;
    logic                 fb;

    always_comb begin
        crc = '0;
        fb  = 1'b0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb  = crc[CRC_WIDTH-1] ^ data_i[i];
            crc = {crc[CRC_WIDTH-2:0], 1'b0};
            if (fb) begin
                crc = crc ^ POLY;
            end
        end
        crc_o = crc;
    end

endmodule

// File: rtl/urp_pcie_flit_crc_check.sv
// rtl/urp_pcie_flit_crc_check.sv - flit CRC checker with 2-entry output FIFO and drop-until-replay FSM
module urp_pcie_flit_crc_check
    import urp_pcie_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int CRC_WIDTH     = CRC_WIDTH_DEF,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flit_valid_i,
    output logic                            flit_ready_o,
    input  logic [DATA_WIDTH+CRC_WIDTH-1:0] flit_data_i,
    output logic                            data_valid_o,
    input  logic                            data_ready_i,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic                            crc_err_o,
    input  logic                            replay_i,
    output logic [ERR_CNT_WIDTH-1:0]        err_cnt_o,
    output logic                            drop_o
);

    logic [DATA_WIDTH-1:0]    payload;
    logic [CRC_WIDTH-1:0]     crc_rx;
    logic [CRC_WIDTH-1:0]     crc_calc;

    flit_state_e              state_q;
    flit_state_e              state_d;

    logic [DATA_WIDTH-1:0]    fifo_mem [FIFO_DEPTH];
    logic                     wr_ptr_q;
    logic                     rd_ptr_q;
    logic [1:0]               count_q;

    logic                     accept;
    logic                     push;
    logic                     pop;
    logic                     crc_bad;
    logic                     crc_err_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

    assign payload = flit_data_i[DATA_WIDTH+CRC_WIDTH-1:CRC_WIDTH];
    assign crc_rx  = flit_data_i[CRC_WIDTH-1:0];

    urp_pcie_crc32_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .CRC_WIDTH  (CRC_WIDTH),
        .POLY       (CRC_WIDTH'(GEN_POLY))
    ) u_crc_gen (
        .data_i (payload),
        .crc_o  (crc_calc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CHECK;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready depends only on registered state/count, so no path from data_ready_i.
    always_comb begin
        state_d      = state_q;
        flit_ready_o = 1'b1;
        drop_o       = 1'b0;
        accept       = 1'b0;
        push         = 1'b0;
        crc_bad      = 1'b0;
        case (state_q)
            ST_CHECK: begin
                flit_ready_o = (count_q != 2'(FIFO_DEPTH));
                accept       = flit_valid_i && flit_ready_o;
                if (accept) begin
                    if (crc_calc == crc_rx) begin
                        push = 1'b1;
                    end else begin
                        crc_bad = 1'b1;
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                drop_o = 1'b1;
                if (replay_i) begin
                    state_d = ST_CHECK;
                end
            end
            default: begin
                state_d = ST_CHECK;
            end
        endcase
    end

    assign pop          = (count_q != 2'd0) && data_ready_i;
    assign data_valid_o = (count_q != 2'd0);
    assign data_o       = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_mem <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= payload;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            crc_err_q <= crc_bad;
            if (crc_bad && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
            end
        end
    end

    assign crc_err_o = crc_err_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_urp_pcie_flit_crc_check.sv
// tb/tb_urp_pcie_flit_crc_check.sv - self-checking bench for urp_pcie_flit_crc_check
module tb_urp_pcie_flit_crc_check;

    localparam int DW    = 224;
    localparam int CW    = 32;
    localparam int EW    = 3;
    localparam int CMAX  = (1 << EW) - 1;
    localparam logic [31:0] POLY = 32'h814141AB;

    logic           clk = 1'b0;
    logic           rst;
    logic           flit_valid_i;
    logic           flit_ready_o;
    logic [DW+CW-1:0] flit_data_i;
    logic           data_valid_o;
    logic           data_ready_i;
    logic [DW-1:0]  data_o;
    logic           crc_err_o;
    logic           replay_i;
    logic [EW-1:0]  err_cnt_o;
    logic           drop_o;

    int n_vec  = 0;
    int n_fail = 0;

    urp_pcie_flit_crc_check #(
        .DATA_WIDTH    (DW),
        .CRC_WIDTH     (CW),
        .ERR_CNT_WIDTH (EW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flit_valid_i (flit_valid_i),
        .flit_ready_o (flit_ready_o),
        .flit_data_i  (flit_data_i),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .data_o       (data_o),
        .crc_err_o    (crc_err_o),
        .replay_i     (replay_i),
        .err_cnt_o    (err_cnt_o),
        .drop_o       (drop_o)
    );

    always #5 clk = ~clk;

    // Polynomial long division of payload * x^32 by x^32 + POLY.
    function automatic logic [31:0] model_crc(input logic [DW-1:0] p);
        logic [DW+31:0] r;
        r = {p, 32'h0};
        for (int i = DW + 31; i >= 32; i--) begin
            if (r[i]) r[i -: 33] = r[i -: 33] ^ {1'b1, POLY};
        end
        return r[31:0];
    endfunction

    function automatic logic [DW+CW-1:0] good_flit(input logic [DW-1:0] p);
        return {p, model_crc(p)};
    endfunction

    function automatic logic [DW+CW-1:0] bad_flit(input logic [DW-1:0] p);
        return {p, model_crc(p) ^ 32'h1};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queue of delivered words, drop flag, error count.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] got[$];
    bit  m_drop = 0;
    bit  m_err  = 0;
    int  m_cnt  = 0;
    bit  m_live = 0;

    always @(posedge clk) begin
        bit m_rdy, acc;
        if (rst) begin
            mq.delete();
            m_drop = 0;
            m_err  = 0;
            m_cnt  = 0;
            m_live = 1;
        end else if (m_live) begin
            m_rdy = m_drop || (mq.size() < 2);
            acc   = flit_valid_i && m_rdy;
            m_err = 0;
            if (mq.size() != 0 && data_ready_i) void'(mq.pop_front());
            if (m_drop) begin
                if (replay_i) m_drop = 0;
            end else if (acc) begin
                if (model_crc(flit_data_i[DW+CW-1:CW]) == flit_data_i[CW-1:0]) begin
                    mq.push_back(flit_data_i[DW+CW-1:CW]);
                end else begin
                    m_err  = 1;
                    m_drop = 1;
                    if (m_cnt != CMAX) m_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("data_valid", 256'(data_valid_o), 256'(mq.size() != 0));
            if (mq.size() != 0) chk("data_o", 256'(data_o), 256'(mq[0]));
            chk("crc_err", 256'(crc_err_o), 256'(m_err));
            chk("err_cnt", 256'(err_cnt_o), 256'(m_cnt));
            chk("drop", 256'(drop_o), 256'(m_drop));
            chk("flit_ready", 256'(flit_ready_o), 256'(m_drop || (mq.size() < 2)));
            if (!rst && data_valid_o && data_ready_i) got.push_back(data_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_flit(input logic [DW+CW-1:0] f);
        bit acc;
        flit_data_i  = f;
        flit_valid_i = 1'b1;
        for (int n = 0; n < 50; n++) begin
            acc = flit_ready_o;
            tick();
            if (acc) begin
                flit_valid_i = 1'b0;
                return;
            end
        end
        flit_valid_i = 1'b0;
        n_vec++;
        n_fail++;
        $display("FAIL send_timeout: flit %0h not accepted within 50 cycles", f);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 256'(data_valid_o), 256'(0));
        chk({tag, "_data"}, 256'(data_o), 256'(0));
        chk({tag, "_ready"}, 256'(flit_ready_o), 256'(1));
        chk({tag, "_cnt"}, 256'(err_cnt_o), 256'(0));
        chk({tag, "_drop"}, 256'(drop_o), 256'(0));
        chk({tag, "_err"}, 256'(crc_err_o), 256'(0));
    endtask

    initial begin
        rst          = 1'b1;
        flit_valid_i = 1'b0;
        flit_data_i  = '0;
        data_ready_i = 1'b1;
        replay_i     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_state("reset");

        chk("model_crc_0", 256'(model_crc(224'd0)), 256'(32'h00000000));
        chk("model_crc_1", 256'(model_crc(224'd1)), 256'(32'h814141AB));
        chk("model_crc_2", 256'(model_crc(224'd2)), 256'(32'h83C3C2FD));

        // All-zero payload with zero CRC passes with latency 1.
        flit_data_i  = '0;
        flit_valid_i = 1'b1;
        tick();
        flit_valid_i = 1'b0;
        chk("zero_valid", 256'(data_valid_o), 256'(1));
        chk("zero_data", 256'(data_o), 256'(0));
        chk("zero_err", 256'(crc_err_o), 256'(0));
        tick();

        // Payload 1: correct CRC passes, off-by-one CRC fails.
        flit_data_i  = {224'd1, 32'h814141AB};
        flit_valid_i = 1'b1;
        tick();
        flit_valid_i = 1'b0;
        chk("one_valid", 256'(data_valid_o), 256'(1));
        chk("one_data", 256'(data_o), 256'(1));
        flit_data_i  = {224'd1, 32'h814141AA};
        flit_valid_i = 1'b1;
        tick();
        flit_valid_i = 1'b0;
        chk("bad_err", 256'(crc_err_o), 256'(1));
        chk("bad_cnt", 256'(err_cnt_o), 256'(1));
        chk("bad_drop", 256'(drop_o), 256'(1));
        chk("bad_valid", 256'(data_valid_o), 256'(0));
        tick();
        chk("bad_err_pulse", 256'(crc_err_o), 256'(0));

        // DROP: three good flits discarded, replay flit discarded, fifth delivered.
        got.delete();
        for (int k = 0; k < 3; k++) send_flit(good_flit(224'(10 + k)));
        replay_i = 1'b1;
        send_flit(good_flit(224'd13));
        replay_i = 1'b0;
        chk("replay_drop_low", 256'(drop_o), 256'(0));
        send_flit(good_flit(224'd14));
        for (int k = 0; k < 3; k++) tick();
        chk("replay_got_n", 256'(got.size()), 256'(1));
        if (got.size() == 1) chk("replay_got_0", 256'(got[0]), 256'(14));

        // Backpressure: ready drops after two accepts, release drains in order.
        got.delete();
        data_ready_i = 1'b0;
        send_flit(good_flit(224'd20));
        send_flit(good_flit(224'd21));
        chk("bp_ready_low", 256'(flit_ready_o), 256'(0));
        flit_data_i  = good_flit(224'd22);
        flit_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("bp_ready_still_low", 256'(flit_ready_o), 256'(0));
        chk("bp_head_stable", 256'(data_o), 256'(20));
        data_ready_i = 1'b1;
        send_flit(good_flit(224'd22));
        send_flit(good_flit(224'd23));
        for (int k = 0; k < 4; k++) tick();
        chk("bp_got_n", 256'(got.size()), 256'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) chk("bp_got_order", 256'(got[k]), 256'(20 + k));
        end

        // Saturation: bring the count to all-ones minus 1, then two more errors.
        for (int k = 0; k < 5; k++) begin
            send_flit(bad_flit(224'(40 + k)));
            replay_i = 1'b1;
            tick();
            replay_i = 1'b0;
        end
        chk("sat_pre", 256'(err_cnt_o), 256'(CMAX - 1));
        send_flit(bad_flit(224'd45));
        replay_i = 1'b1;
        tick();
        replay_i = 1'b0;
        chk("sat_full", 256'(err_cnt_o), 256'(CMAX));
        send_flit(bad_flit(224'd46));
        replay_i = 1'b1;
        tick();
        replay_i = 1'b0;
        chk("sat_hold", 256'(err_cnt_o), 256'(CMAX));

        // Mid-stream reset with two buffered words and a flit presented.
        data_ready_i = 1'b0;
        send_flit(good_flit(224'd50));
        send_flit(good_flit(224'd51));
        rst          = 1'b1;
        flit_data_i  = good_flit(224'd52);
        flit_valid_i = 1'b1;
        tick();
        rst          = 1'b0;
        flit_valid_i = 1'b0;
        chk_reset_state("rst_full");

        // Reset while in DROP with a buffered word.
        send_flit(good_flit(224'd60));
        send_flit(bad_flit(224'd61));
        chk("rst_drop_pre", 256'(drop_o), 256'(1));
        rst          = 1'b1;
        flit_data_i  = good_flit(224'd62);
        flit_valid_i = 1'b1;
        tick();
        rst          = 1'b0;
        flit_valid_i = 1'b0;
        chk_reset_state("rst_drop");

        data_ready_i = 1'b1;
        send_flit(good_flit(224'd63));
        for (int k = 0; k < 3; k++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
